clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl.sv | 128 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Idle-driven clock-gate enable controller with a four-phase wake
//            handshake and a saturating gated-cycle statistics counter.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_DLY = 2,
    parameter int CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cg_enable,
    input  logic [IDLE_W-1:0] i_idle_thresh,
    input  logic              i_busy,
    input  logic              i_wake_req,
    output logic              o_wake_ack,
    input  logic              i_test_en,
    output logic              o_clk_en,
    output logic              o_gated,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_gated_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_COUNT = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [3:0] c_WAKE_LOAD = 4'(WAKE_DLY);

    state_t              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [3:0]          wake_cnt_q, wake_cnt_d;
    logic                clk_en_q;
    logic                gated_q;
    logic                ack_q;
    logic [CNT_W-1:0]    gated_cnt_q;
    logic                w_idle;
    logic                w_wake_cond;

    assign w_idle      = i_cg_enable & ~i_busy & ~i_wake_req & (i_idle_thresh != '0);
    assign w_wake_cond = i_busy | i_wake_req | ~i_cg_enable;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (w_idle) begin
                    state_d    = ST_COUNT;
                    idle_cnt_d = IDLE_W'(1);
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_COUNT: begin
                // Threshold is compared live, so lowering it mid-count gates at once.
                if (!w_idle) begin
                    state_d    = ST_RUN;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q >= i_idle_thresh) begin
                    state_d    = ST_GATED;
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            ST_GATED: begin
                idle_cnt_d = '0;
                if (w_wake_cond) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = c_WAKE_LOAD;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q <= 4'd1) begin
                    state_d    = ST_RUN;
                    wake_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
                wake_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            clk_en_q    <= 1'b1;
            gated_q     <= 1'b0;
            ack_q       <= 1'b0;
            gated_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            // Enable drops only after a full cycle in GATED, but rises on the wake edge.
            clk_en_q   <= !((state_q == ST_GATED) && (state_d == ST_GATED));
            gated_q    <= (state_q == ST_GATED);
            ack_q      <= (state_q == ST_RUN) && i_wake_req;
            if (i_cnt_clr) begin
                gated_cnt_q <= '0;
            end else if ((state_q == ST_GATED) && (gated_cnt_q != '1)) begin
                gated_cnt_q <= gated_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_clk_en    = clk_en_q | i_test_en;
    assign o_gated     = gated_q;
    assign o_wake_ack  = ack_q;
    assign o_gated_cnt = gated_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gate_ctrl
// Brief    : Directed vector table plus hand sequences for clk_gate_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cg_en;
    logic [7:0]  thr;
    logic        busy;
    logic        req;
    logic        ack;
    logic        ten;
    logic        clk_en;
    logic        gated;
    logic        clr;
    logic [15:0] gcnt;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        rst_n;
        logic        cg;
        logic [7:0]  thr;
        logic        busy;
        logic        req;
        logic        ten;
        logic        clr;
        logic        en;
        logic        gated;
        logic        ack;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[47];

    clk_gate_ctrl #(
        .IDLE_W  (8),
        .WAKE_DLY(2),
        .CNT_W   (16)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cg_enable  (cg_en),
        .i_idle_thresh(thr),
        .i_busy       (busy),
        .i_wake_req   (req),
        .o_wake_ack   (ack),
        .i_test_en    (ten),
        .o_clk_en     (clk_en),
        .o_gated      (gated),
        .i_cnt_clr    (clr),
        .o_gated_cnt  (gcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic c, input logic [7:0] t,
                                input logic b, input logic q, input logic te,
                                input logic cl, input logic e, input logic g,
                                input logic a, input logic [15:0] n);
        vec_t v;
        v.rst_n = r; v.cg = c; v.thr = t; v.busy = b; v.req = q; v.ten = te;
        v.clr = cl; v.en = e; v.gated = g; v.ack = a; v.cnt = n;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic [7:0] t,
                         input logic b, input logic q, input logic te, input logic cl);
        rst_n = r; cg_en = c; thr = t; busy = b; req = q; ten = te; clr = cl;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        drive(1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);

        //              rst cg thr  bsy req ten clr   en  g   a   cnt
        vecs[0]  = mk(0, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[1]  = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[2]  = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[3]  = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[4]  = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[5]  = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[6]  = mk(1, 1, 8'd4,  0, 0, 0, 0,   0, 1, 0, 16'd1);
        vecs[7]  = mk(1, 1, 8'd4,  0, 0, 0, 0,   0, 1, 0, 16'd2);
        vecs[8]  = mk(1, 1, 8'd4,  0, 1, 0, 0,   1, 1, 0, 16'd3);
        vecs[9]  = mk(1, 1, 8'd4,  0, 1, 0, 0,   1, 0, 0, 16'd3);
        vecs[10] = mk(1, 1, 8'd4,  0, 1, 0, 0,   1, 0, 0, 16'd3);
        vecs[11] = mk(1, 1, 8'd4,  0, 1, 0, 0,   1, 0, 1, 16'd3);
        vecs[12] = mk(1, 1, 8'd4,  0, 1, 0, 0,   1, 0, 1, 16'd3);
        vecs[13] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[14] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[15] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[16] = mk(1, 1, 8'd4,  1, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[17] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[18] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[19] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[20] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[21] = mk(1, 1, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd3);
        vecs[22] = mk(1, 1, 8'd4,  0, 0, 0, 0,   0, 1, 0, 16'd4);
        vecs[23] = mk(1, 1, 8'd4,  0, 0, 1, 0,   1, 1, 0, 16'd5);
        vecs[24] = mk(1, 1, 8'd4,  0, 0, 0, 0,   0, 1, 0, 16'd6);
        vecs[25] = mk(1, 1, 8'd4,  0, 0, 0, 1,   0, 1, 0, 16'd0);
        vecs[26] = mk(1, 1, 8'd4,  0, 0, 0, 0,   0, 1, 0, 16'd1);
        vecs[27] = mk(1, 0, 8'd4,  0, 0, 0, 0,   1, 1, 0, 16'd2);
        vecs[28] = mk(1, 0, 8'd4,  0, 0, 0, 0,   1, 0, 0, 16'd2);
        vecs[29] = mk(0, 0, 8'd4,  0, 1, 0, 0,   1, 0, 0, 16'd0);
        vecs[30] = mk(1, 1, 8'd0,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[31] = mk(1, 1, 8'd0,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[32] = mk(1, 1, 8'd0,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[33] = mk(1, 1, 8'd1,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[34] = mk(1, 1, 8'd1,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[35] = mk(1, 1, 8'd1,  0, 0, 0, 0,   0, 1, 0, 16'd1);
        vecs[36] = mk(0, 1, 8'd1,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[37] = mk(1, 0, 8'd1,  0, 1, 0, 0,   1, 0, 1, 16'd0);
        vecs[38] = mk(1, 0, 8'd1,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[39] = mk(1, 1, 8'd10, 0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[40] = mk(1, 1, 8'd10, 0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[41] = mk(1, 1, 8'd10, 0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[42] = mk(1, 1, 8'd2,  0, 0, 0, 0,   1, 0, 0, 16'd0);
        vecs[43] = mk(1, 1, 8'd2,  0, 0, 0, 0,   0, 1, 0, 16'd1);
        vecs[44] = mk(1, 1, 8'd2,  1, 0, 0, 0,   1, 1, 0, 16'd2);
        vecs[45] = mk(1, 1, 8'd2,  0, 0, 0, 0,   1, 0, 0, 16'd2);
        vecs[46] = mk(1, 1, 8'd2,  0, 0, 0, 0,   1, 0, 0, 16'd2);

        @(negedge clk);
        for (int i = 0; i < 47; i++) begin
            drive(vecs[i].rst_n, vecs[i].cg, vecs[i].thr, vecs[i].busy,
                  vecs[i].req, vecs[i].ten, vecs[i].clr);
            tick();
            chk($sformatf("v%0d_clk_en", i), 32'(clk_en), 32'(vecs[i].en));
            chk($sformatf("v%0d_gated",  i), 32'(gated),  32'(vecs[i].gated));
            chk($sformatf("v%0d_ack",    i), 32'(ack),    32'(vecs[i].ack));
            chk($sformatf("v%0d_cnt",    i), 32'(gcnt),   32'(vecs[i].cnt));
        end

        // Long gated stretch, then clear while gating continues.
        drive(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        for (int k = 0; k < 100; k++) tick();
        chk("long_cnt",    32'(gcnt),   32'd100);
        chk("long_clk_en", 32'(clk_en), 32'd0);
        chk("long_gated",  32'(gated),  32'd1);
        clr = 1'b1;
        tick();
        chk("clr_cnt", 32'(gcnt), 32'd0);
        clr = 1'b0;
        tick();
        chk("post_clr_cnt", 32'(gcnt), 32'd1);

        // Request withdrawn before ack: wake completes, no ack pulse.
        req = 1'b1;
        tick();
        chk("abort_en_e0", 32'(clk_en), 32'd1);
        chk("abort_ack_e0", 32'(ack), 32'd0);
        req = 1'b0;
        busy = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("abort_en_e%0d", k),  32'(clk_en), 32'd1);
            chk($sformatf("abort_ack_e%0d", k), 32'(ack),    32'd0);
        end
        chk("abort_gated", 32'(gated), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
